store_align_unit: RTL and testbench



---
 rtl/store_align_unit_pkg.sv | 31 +++
 rtl/store_align_unit_shift.sv | 34 +++
 rtl/store_align_unit.sv | 178 +++++++++++++++++
 tb/tb_store_align_unit.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_align_unit_pkg.sv
// Shared types for the store aligner: store size encoding, FSM states and size decode.
package store_align_unit_pkg;

    localparam int unsigned STORE_DATA_W = 64;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2,
        ST_DONE  = 2'd3
    } store_state_e;

    // Unknown encodings decode to an empty store.
    function automatic logic [3:0] msize_bytes(input msize_t m);
        case (m)
            MSIZE1:  return 4'd1;
            MSIZE2:  return 4'd2;
            MSIZE4:  return 4'd4;
            MSIZE8:  return 4'd8;
            default: return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/store_align_unit_shift.sv
// Combinational lane shifter: places n store bytes at a byte offset over two bus words.
module store_align_unit_shift
    import store_align_unit_pkg::*;
#(
    parameter int unsigned BUS_BYTES = 8,
    parameter int unsigned OFF_W     = 3
) (
    input  msize_t                    msize_i,
    input  logic [STORE_DATA_W-1:0]   data_i,
    input  logic [OFF_W-1:0]          offset_i,
    output logic [2*BUS_BYTES-1:0]    strb_o,
    output logic [16*BUS_BYTES-1:0]   data_o
);

    localparam int unsigned WIDE_B = 2 * BUS_BYTES;
    localparam int unsigned WIDE_W = 16 * BUS_BYTES;

    logic [3:0]              n_bytes;
    logic [8:0]              mask9;
    logic [7:0]              byte_mask;
    logic [STORE_DATA_W-1:0] data_masked;

    always_comb begin
        n_bytes   = msize_bytes(msize_i);
        mask9     = (9'd1 << n_bytes) - 9'd1;
        byte_mask = mask9[7:0];
        for (int i = 0; i < 8; i++) begin
            data_masked[i*8 +: 8] = byte_mask[i] ? data_i[i*8 +: 8] : 8'h00;
        end
        strb_o = WIDE_B'(byte_mask) << offset_i;
        data_o = WIDE_W'(data_masked) << {offset_i, 3'b000};
    end

endmodule

// File: rtl/store_align_unit.sv
// Sequential store aligner: one request per handshake, one or two strobed bus beats, done/fault pulse.
// Build option STORE_SPLIT_EN: accept and split misaligned stores; otherwise they are faulted.
module store_align_unit
    import store_align_unit_pkg::*;
#(
    parameter int unsigned BUS_BYTES = 8,
    parameter int unsigned ADDR_W    = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ADDR_W-1:0]         in_addr,
    input  logic [STORE_DATA_W-1:0]   in_data,
    input  msize_t                    in_msize,
    output logic                      mem_valid,
    input  logic                      mem_ready,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [BUS_BYTES-1:0]      mem_strobe,
    output logic [8*BUS_BYTES-1:0]    mem_data,
    output logic                      done,
    output logic                      fault
);

    localparam int unsigned OFF_W  = $clog2(BUS_BYTES);
    localparam int unsigned WIDE_B = 2 * BUS_BYTES;
    localparam int unsigned WIDE_W = 16 * BUS_BYTES;
    localparam int unsigned BEAT_W = 8 * BUS_BYTES;

    typedef logic [BUS_BYTES-1:0] strb_t;

    if (!(BUS_BYTES == 8 || BUS_BYTES == 16 || BUS_BYTES == 32)) begin : g_bad_bus
        $error("store_align_unit: BUS_BYTES must be 8, 16 or 32");
    end

    store_state_e       state_q, state_d;
    logic [WIDE_B-1:0]  strb_q, strb_d;
    logic [WIDE_W-1:0]  wdata_q, wdata_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic               in_ready_q, in_ready_d;
    logic               mem_valid_q, mem_valid_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    strb_t              mem_strobe_q, mem_strobe_d;
    logic [BEAT_W-1:0]  mem_data_q, mem_data_d;
    logic               done_q, done_d;
    logic               fault_q, fault_d;

    logic [WIDE_B-1:0]  shift_strb;
    logic [WIDE_W-1:0]  shift_data;
    logic [3:0]         req_bytes;

    store_align_unit_shift #(
        .BUS_BYTES (BUS_BYTES),
        .OFF_W     (OFF_W)
    ) u_shift (
        .msize_i  (in_msize),
        .data_i   (in_data),
        .offset_i (in_addr[OFF_W-1:0]),
        .strb_o   (shift_strb),
        .data_o   (shift_data)
    );

    assign req_bytes = msize_bytes(in_msize);

`ifndef STORE_SPLIT_EN
    logic misaligned;
    assign misaligned = (req_bytes != 4'd0) &&
                        ((in_addr[3:0] & (req_bytes - 4'd1)) != 4'd0);
`endif

    // Next state, request latch, then registered outputs decoded from the next state.
    always_comb begin
        state_d = state_q;
        strb_d  = strb_q;
        wdata_d = wdata_q;
        base_d  = base_q;
        fault_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    strb_d  = shift_strb;
                    wdata_d = shift_data;
                    base_d  = {in_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
                    if (req_bytes == 4'd0) begin
                        state_d = ST_DONE;
                    end
`ifndef STORE_SPLIT_EN
                    else if (misaligned) begin
                        fault_d = 1'b1;
                    end
`endif
                    else begin
                        state_d = ST_BEAT0;
                    end
                end
            end
            ST_BEAT0: begin
                if (mem_ready) begin
`ifdef STORE_SPLIT_EN
                    state_d = (|strb_q[WIDE_B-1:BUS_BYTES]) ? ST_BEAT1 : ST_DONE;
`else
                    state_d = ST_DONE;
`endif
                end
            end
            ST_BEAT1: begin
                if (mem_ready) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        in_ready_d   = 1'b0;
        mem_valid_d  = 1'b0;
        mem_addr_d   = '0;
        mem_strobe_d = '0;
        mem_data_d   = '0;
        done_d       = 1'b0;

        case (state_d)
            ST_IDLE:  in_ready_d = 1'b1;
            ST_BEAT0: begin
                mem_valid_d  = 1'b1;
                mem_addr_d   = base_d;
                mem_strobe_d = strb_d[BUS_BYTES-1:0];
                mem_data_d   = wdata_d[BEAT_W-1:0];
            end
            ST_BEAT1: begin
                mem_valid_d  = 1'b1;
                mem_addr_d   = base_d + ADDR_W'(BUS_BYTES);
                mem_strobe_d = strb_d[WIDE_B-1:BUS_BYTES];
                mem_data_d   = wdata_d[WIDE_W-1:BEAT_W];
            end
            ST_DONE:  done_d = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            strb_q       <= '0;
            wdata_q      <= '0;
            base_q       <= '0;
            in_ready_q   <= 1'b1;
            mem_valid_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_strobe_q <= '0;
            mem_data_q   <= '0;
            done_q       <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            strb_q       <= strb_d;
            wdata_q      <= wdata_d;
            base_q       <= base_d;
            in_ready_q   <= in_ready_d;
            mem_valid_q  <= mem_valid_d;
            mem_addr_q   <= mem_addr_d;
            mem_strobe_q <= mem_strobe_d;
            mem_data_q   <= mem_data_d;
            done_q       <= done_d;
            fault_q      <= fault_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign mem_valid  = mem_valid_q;
    assign mem_addr   = mem_addr_q;
    assign mem_strobe = mem_strobe_q;
    assign mem_data   = mem_data_q;
    assign done       = done_q;
    assign fault      = fault_q;

endmodule

// File: tb/tb_store_align_unit.sv
// Directed bench for store_align_unit: 8-byte and 16-byte bus instances, both STORE_SPLIT_EN builds.
module tb_store_align_unit;
    import store_align_unit_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [63:0]  in_addr = '0;
    logic [63:0]  in_data = '0;
    msize_t       in_msize = MSIZE1;
    logic         mem_valid;
    logic         mem_ready = 1'b1;
    logic [63:0]  mem_addr;
    logic [7:0]   mem_strobe;
    logic [63:0]  mem_data;
    logic         done;
    logic         fault;

    logic         v16 = 1'b0;
    logic         r16;
    logic [63:0]  a16 = '0;
    logic [63:0]  d16 = '0;
    msize_t       s16 = MSIZE1;
    logic         mv16;
    logic [63:0]  ma16;
    logic [15:0]  ms16;
    logic [127:0] md16;
    logic         dn16;
    logic         ft16;

    store_align_unit #(.BUS_BYTES(8), .ADDR_W(64)) u_dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
        .in_data(in_data), .in_msize(in_msize),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_strobe(mem_strobe), .mem_data(mem_data),
        .done(done), .fault(fault)
    );

    store_align_unit #(.BUS_BYTES(16), .ADDR_W(64)) u_dut16 (
        .clk(clk), .reset(reset),
        .in_valid(v16), .in_ready(r16), .in_addr(a16),
        .in_data(d16), .in_msize(s16),
        .mem_valid(mv16), .mem_ready(1'b1), .mem_addr(ma16),
        .mem_strobe(ms16), .mem_data(md16),
        .done(dn16), .fault(ft16)
    );

    int n_cmp = 0;
    int n_err = 0;

    int          nb, n_done, n_fault, done_cyc, fault_cyc;
    logic [63:0] b_addr [2];
    logic [7:0]  b_strb [2];
    logic [63:0] b_data [2];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one store to the 8-byte instance and record beats/pulses for 12 cycles.
    // Cycle 1 is the first sample after the accept edge.
    task automatic do_store(input logic [63:0] a, input logic [63:0] d, input msize_t sz);
        in_addr = a; in_data = d; in_msize = sz; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        nb = 0; n_done = 0; n_fault = 0; done_cyc = 0; fault_cyc = 0;
        for (int i = 1; i <= 12; i++) begin
            if (mem_valid && mem_ready) begin
                if (nb < 2) begin
                    b_addr[nb] = mem_addr; b_strb[nb] = mem_strobe; b_data[nb] = mem_data;
                end
                nb++;
            end
            if (done) begin
                n_done++;
                if (done_cyc == 0) done_cyc = i;
            end
            if (fault) begin
                n_fault++;
                if (fault_cyc == 0) fault_cyc = i;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic saw_done;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_strobe", mem_strobe, 0);
        chk("rst_mem_data", mem_data, 0);
        chk("rst_done", done, 0);
        chk("rst_fault", fault, 0);
        chk("rst16_in_ready", r16, 1);
        reset = 1'b0;
        @(posedge clk); #1;

        // sd aligned: one full beat, done on the third cycle counting the accept cycle
        do_store(64'h1000, 64'h1122334455667788, MSIZE8);
        chk("sd_beats", nb, 1);
        chk("sd_addr", b_addr[0], 64'h1000);
        chk("sd_strb", b_strb[0], 8'hFF);
        chk("sd_data", b_data[0], 64'h1122334455667788);
        chk("sd_done_cyc", done_cyc, 2);
        chk("sd_n_done", n_done, 1);
        chk("sd_n_fault", n_fault, 0);

        // sb with junk in upper data bytes
        do_store(64'h1005, 64'hFFFF_FFFF_FFFF_FFAB, MSIZE1);
        chk("sb_beats", nb, 1);
        chk("sb_addr", b_addr[0], 64'h1000);
        chk("sb_strb", b_strb[0], 8'h20);
        chk("sb_data", b_data[0], 64'h0000_AB00_0000_0000);
        chk("sb_done_cyc", done_cyc, 2);

        // sh aligned at offset 2
        do_store(64'h1002, 64'h5555_5555_5555_1234, MSIZE2);
        chk("sh_beats", nb, 1);
        chk("sh_strb", b_strb[0], 8'h0C);
        chk("sh_data", b_data[0], 64'h0000_0000_1234_0000);

        // sw ending exactly at the bus-word boundary stays one beat
        do_store(64'h100C, 64'h0000_0000_DEAD_BEEF, MSIZE4);
        chk("swtop_beats", nb, 1);
        chk("swtop_addr", b_addr[0], 64'h1008);
        chk("swtop_strb", b_strb[0], 8'hF0);
        chk("swtop_data", b_data[0], 64'hDEAD_BEEF_0000_0000);

        // unknown size: empty store, done with no beat
        do_store(64'h1003, 64'h1234, msize_t'(3'd5));
        chk("empty_beats", nb, 0);
        chk("empty_done_cyc", done_cyc, 1);
        chk("empty_n_done", n_done, 1);
        chk("empty_n_fault", n_fault, 0);

        // misaligned sw crossing the bus word
        do_store(64'h1006, 64'h0000_0000_DEAD_BEEF, MSIZE4);
`ifdef STORE_SPLIT_EN
        chk("split_beats", nb, 2);
        chk("split_b0_addr", b_addr[0], 64'h1000);
        chk("split_b0_strb", b_strb[0], 8'hC0);
        chk("split_b0_data", b_data[0], 64'hBEEF_0000_0000_0000);
        chk("split_b1_addr", b_addr[1], 64'h1008);
        chk("split_b1_strb", b_strb[1], 8'h03);
        chk("split_b1_data", b_data[1], 64'h0000_0000_0000_DEAD);
        chk("split_done_cyc", done_cyc, 3);
        chk("split_n_done", n_done, 1);
        chk("split_n_fault", n_fault, 0);

        // beat1 address wraps past the top of the address space
        do_store(64'hFFFF_FFFF_FFFF_FFFC, 64'h8877_6655_4433_2211, MSIZE8);
        chk("wrap_beats", nb, 2);
        chk("wrap_b0_addr", b_addr[0], 64'hFFFF_FFFF_FFFF_FFF8);
        chk("wrap_b0_strb", b_strb[0], 8'hF0);
        chk("wrap_b0_data", b_data[0], 64'h4433_2211_0000_0000);
        chk("wrap_b1_addr", b_addr[1], 64'h0);
        chk("wrap_b1_strb", b_strb[1], 8'h0F);
        chk("wrap_b1_data", b_data[1], 64'h0000_0000_8877_6655);
`else
        chk("mis_beats", nb, 0);
        chk("mis_fault_cyc", fault_cyc, 1);
        chk("mis_n_fault", n_fault, 1);
        chk("mis_n_done", n_done, 0);
`endif

        // back-pressure: beat held for 5 cycles, new requests ignored meanwhile
        mem_ready = 1'b0;
        in_addr = 64'h2000; in_data = 64'hCAFE_F00D_0123_4567; in_msize = MSIZE8; in_valid = 1'b1;
        @(posedge clk); #1;
        in_addr = 64'h3000; in_data = 64'h1; in_msize = MSIZE1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", mem_valid, 1);
            chk("bp_addr", mem_addr, 64'h2000);
            chk("bp_strb", mem_strobe, 8'hFF);
            chk("bp_data", mem_data, 64'hCAFE_F00D_0123_4567);
            chk("bp_in_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; mem_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_done", done, 1);
        chk("bp_valid_after", mem_valid, 0);
        chk("bp_in_ready_done", in_ready, 0);
        @(posedge clk); #1;
        chk("bp_idle_ready", in_ready, 1);
        chk("bp_done_once", done, 0);
        @(posedge clk); #1;
        chk("bp_no_ghost", mem_valid, 0);

        // reset in the middle of a transaction
`ifdef STORE_SPLIT_EN
        in_addr = 64'h1006; in_data = 64'hDEAD_BEEF; in_msize = MSIZE4; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        chk("mid_b1_addr", mem_addr, 64'h1008);
        chk("mid_b1_valid", mem_valid, 1);
`else
        mem_ready = 1'b0;
        in_addr = 64'h1000; in_data = 64'h77; in_msize = MSIZE8; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("mid_b0_valid", mem_valid, 1);
`endif
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_valid", mem_valid, 0);
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_strobe", mem_strobe, 0);
        reset = 1'b0; mem_ready = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (done || mem_valid) saw_done = 1'b1;
        end
        chk("mid_rst_quiet", saw_done, 0);

        // 16-byte bus instance
        a16 = 64'h108; d16 = 64'h0102_0304_0506_0708; s16 = MSIZE8; v16 = 1'b1;
        @(posedge clk); #1;
        v16 = 1'b0;
        chk("b16_sd_addr", ma16, 64'h100);
        chk("b16_sd_strb", ms16, 16'hFF00);
        chk("b16_sd_data", md16, {64'h0102_0304_0506_0708, 64'h0});
        @(posedge clk); #1;
        chk("b16_sd_done", dn16, 1);
        @(posedge clk); #1;

        a16 = 64'h10F; d16 = 64'h1234; s16 = MSIZE2; v16 = 1'b1;
        @(posedge clk); #1;
        v16 = 1'b0;
`ifdef STORE_SPLIT_EN
        chk("b16_sh_b0_addr", ma16, 64'h100);
        chk("b16_sh_b0_strb", ms16, 16'h8000);
        chk("b16_sh_b0_data", md16, {8'h34, 120'h0});
        @(posedge clk); #1;
        chk("b16_sh_b1_addr", ma16, 64'h110);
        chk("b16_sh_b1_strb", ms16, 16'h0001);
        chk("b16_sh_b1_data", md16, 128'h12);
        @(posedge clk); #1;
        chk("b16_sh_done", dn16, 1);
`else
        chk("b16_sh_fault", ft16, 1);
        chk("b16_sh_novalid", mv16, 0);
        @(posedge clk); #1;
        chk("b16_sh_nodone", dn16, 0);
`endif
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
